// File: rtl/iagc_peak_detector.sv
// iagc_peak_detector: AXI-Stream ADC sink that reports the per-window peak |sample| plus threshold flags.
// Define IAGC_PEAK_OVERRANGE_EN to track full-scale codes on o_overrange; otherwise it is tied to 0.
module iagc_peak_detector #(
    parameter int ZMOD_DATA_SIZE = 14,
    parameter int AXIS_DATA_SIZE = 32,
    parameter int WINDOW_SIZE    = 1024
) (
    input  logic                      i_sys_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_channel,
    input  logic [ZMOD_DATA_SIZE-1:0] i_thr_high,
    input  logic [ZMOD_DATA_SIZE-1:0] i_thr_low,
    input  logic [AXIS_DATA_SIZE-1:0] i_axis_tdata,
    input  logic                      i_axis_tvalid,
    output logic                      o_axis_tready,
    output logic [ZMOD_DATA_SIZE-1:0] o_peak,
    output logic                      o_above,
    output logic                      o_below,
    output logic                      o_overrange,
    output logic                      o_peak_valid,
    input  logic                      i_peak_ready
);

    localparam int                CNT_W    = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_e;

    // |s| of a two's-complement sample; the most negative code maps onto 2^(W-1) without wrapping.
    function automatic logic [ZMOD_DATA_SIZE-1:0] mag_f(input logic signed [ZMOD_DATA_SIZE-1:0] s);
        logic [ZMOD_DATA_SIZE-1:0] u;
        u = s;
        return s[ZMOD_DATA_SIZE-1] ? (~u + ZMOD_DATA_SIZE'(1)) : u;
    endfunction

    function automatic logic [ZMOD_DATA_SIZE-1:0] max_f(input logic [ZMOD_DATA_SIZE-1:0] a,
                                                        input logic [ZMOD_DATA_SIZE-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_e                      state_q, state_d;
    logic                        rdy_en_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        chan_q, chan_d;
    logic                        vld_p1_q, vld_p1_d;
    logic                        last_p1_q, last_p1_d;
    logic [ZMOD_DATA_SIZE-1:0]   mag_p1_q, mag_p1_d;
    logic [ZMOD_DATA_SIZE-1:0]   acc_q, acc_d;
    logic [ZMOD_DATA_SIZE-1:0]   peak_q, peak_d;
    logic                        above_q, above_d;
    logic                        below_q, below_d;
    logic                        peak_valid_q, peak_valid_d;

    logic                        run_c;
    logic                        at_last_c;
    logic                        stall_c;
    logic                        tready_c;
    logic                        accept_c;
    logic                        load_c;
    logic                        chan_sel_c;
    logic signed [ZMOD_DATA_SIZE-1:0] sample_c;
    logic [ZMOD_DATA_SIZE-1:0]   win_peak_c;

    // Only the two 14-bit channel fields of each stream word carry sample data.
    logic                        tdata_unused;
    assign tdata_unused = ^i_axis_tdata;

    // Handshake and stall decode; the ready path from i_peak_ready is purely combinational.
    always_comb begin
        run_c      = i_enable && (state_q != IDLE);
        at_last_c  = (cnt_q == CNT_LAST);
        stall_c    = run_c && at_last_c && peak_valid_q && !i_peak_ready;
        tready_c   = rdy_en_q && !stall_c;
        accept_c   = run_c && i_axis_tvalid && tready_c;
        load_c     = run_c && vld_p1_q && last_p1_q;
        chan_sel_c = (cnt_q == '0) ? i_channel : chan_q;
        sample_c   = chan_sel_c ? i_axis_tdata[AXIS_DATA_SIZE/2-1 -: ZMOD_DATA_SIZE]
                                : i_axis_tdata[AXIS_DATA_SIZE-1   -: ZMOD_DATA_SIZE];
        win_peak_c = max_f(acc_q, mag_p1_q);
    end

    assign o_axis_tready = tready_c;

    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ACCUM;
                ACCUM:   if (stall_c) state_d = STALL;
                STALL:   if (!stall_c) state_d = ACCUM;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 0 -> 1: window counter, channel capture, magnitude and last-of-window tag
    always_comb begin
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        if (!run_c) begin
            cnt_d = '0;
        end else if (accept_c) begin
            cnt_d = at_last_c ? '0 : cnt_q + CNT_W'(1);
            if (cnt_q == '0) chan_d = i_channel;
        end
        vld_p1_d  = accept_c;
        last_p1_d = accept_c && at_last_c;
        mag_p1_d  = mag_f(sample_c);
    end

    // Stage 1 -> 2: running max and result register load
    always_comb begin
        acc_d        = acc_q;
        peak_d       = peak_q;
        above_d      = above_q;
        below_d      = below_q;
        peak_valid_d = peak_valid_q && !i_peak_ready;
        if (!run_c) begin
            acc_d = '0;
        end else if (vld_p1_q) begin
            acc_d = last_p1_q ? '0 : win_peak_c;
        end
        if (load_c) begin
            peak_d       = win_peak_c;
            above_d      = (win_peak_c > i_thr_high);
            below_d      = (win_peak_c < i_thr_low);
            peak_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            rdy_en_q     <= 1'b0;
            cnt_q        <= '0;
            chan_q       <= 1'b0;
            vld_p1_q     <= 1'b0;
            last_p1_q    <= 1'b0;
            peak_q       <= '0;
            above_q      <= 1'b0;
            below_q      <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            cnt_q        <= cnt_d;
            chan_q       <= chan_d;
            vld_p1_q     <= vld_p1_d;
            last_p1_q    <= last_p1_d;
            peak_q       <= peak_d;
            above_q      <= above_d;
            below_q      <= below_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    // Datapath registers carry no reset; every consumer is qualified by a reset control bit.
    always_ff @(posedge i_sys_clock) begin
        mag_p1_q <= mag_p1_d;
        acc_q    <= acc_d;
    end

    assign o_peak       = peak_q;
    assign o_above      = above_q;
    assign o_below      = below_q;
    assign o_peak_valid = peak_valid_q;

`ifdef IAGC_PEAK_OVERRANGE_EN
    function automatic logic is_full_scale_f(input logic signed [ZMOD_DATA_SIZE-1:0] s);
        return (s == {1'b0, {(ZMOD_DATA_SIZE-1){1'b1}}}) || (s == {1'b1, {(ZMOD_DATA_SIZE-1){1'b0}}});
    endfunction

    logic ovr_p1_q, ovr_p1_d;
    logic ovr_acc_q, ovr_acc_d;
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_p1_d  = is_full_scale_f(sample_c);
        ovr_acc_d = ovr_acc_q;
        ovr_d     = ovr_q;
        if (!run_c) begin
            ovr_acc_d = 1'b0;
        end else if (vld_p1_q) begin
            ovr_acc_d = last_p1_q ? 1'b0 : (ovr_acc_q || ovr_p1_q);
        end
        if (load_c) ovr_d = ovr_acc_q || ovr_p1_q;
    end

    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovr_acc_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ovr_acc_q <= ovr_acc_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge i_sys_clock) begin
        ovr_p1_q <= ovr_p1_d;
    end

    assign o_overrange = ovr_q;
`else
    assign o_overrange = 1'b0;
`endif

endmodule

// File: tb/tb_iagc_peak_detector.sv
// Directed bench for iagc_peak_detector (WINDOW_SIZE=4): window-level model compared every cycle plus literal checks.
module tb_iagc_peak_detector;

    localparam int ZW = 14;
    localparam int AW = 32;
    localparam int WS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, chan, tvalid, tready, pready;
    logic          valid, above, below, ovr;
    logic [ZW-1:0] thr_h, thr_l, peak;
    logic [AW-1:0] tdata;

    int n_vec = 0;
    int n_err = 0;

    iagc_peak_detector #(
        .ZMOD_DATA_SIZE(ZW),
        .AXIS_DATA_SIZE(AW),
        .WINDOW_SIZE(WS)
    ) dut (
        .i_sys_clock  (clk),
        .i_reset_n    (rst_n),
        .i_enable     (en),
        .i_channel    (chan),
        .i_thr_high   (thr_h),
        .i_thr_low    (thr_l),
        .i_axis_tdata (tdata),
        .i_axis_tvalid(tvalid),
        .o_axis_tready(tready),
        .o_peak       (peak),
        .o_above      (above),
        .o_below      (below),
        .o_overrange  (ovr),
        .o_peak_valid (valid),
        .i_peak_ready (pready)
    );

    always #5 clk = ~clk;

    // Window-level model: accepted-sample count, running max, pending result, output register.
    bit            m_rdy_en, m_active, m_chan, m_ovr_acc, m_fly, m_fly_ovr;
    int            m_cnt, m_max, m_fly_val;
    logic [ZW-1:0] m_peak;
    bit            m_above, m_below, m_ovr_o, m_valid;

    function automatic bit exp_tready();
        return m_rdy_en && !(en && m_active && (m_cnt == WS-1) && m_valid && !pready);
    endfunction

    function automatic int cur_samp();
        logic signed [ZW-1:0] s;
        bit c;
        c = (m_cnt == 0) ? chan : m_chan;
        s = c ? tdata[15:2] : tdata[31:18];
        return int'(s);
    endfunction

    function automatic int cur_mag();
        int s;
        s = cur_samp();
        return (s < 0) ? -s : s;
    endfunction

    function automatic bit cur_full();
`ifdef IAGC_PEAK_OVERRANGE_EN
        int s;
        s = cur_samp();
        return (s == 8191) || (s == -8192);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy_en <= 0; m_active <= 0; m_chan <= 0; m_ovr_acc <= 0;
            m_fly <= 0; m_fly_ovr <= 0; m_cnt <= 0; m_max <= 0; m_fly_val <= 0;
            m_peak <= '0; m_above <= 0; m_below <= 0; m_ovr_o <= 0; m_valid <= 0;
        end else begin
            m_rdy_en <= 1;
            m_active <= en;
            m_valid  <= m_valid && !pready;
            m_fly    <= 0;
            if (m_fly && en) begin
                m_valid <= 1;
                m_peak  <= m_fly_val[ZW-1:0];
                m_above <= m_fly_val > int'(thr_h);
                m_below <= m_fly_val < int'(thr_l);
                m_ovr_o <= m_fly_ovr;
            end
            if (!en) begin
                m_cnt <= 0; m_max <= 0; m_ovr_acc <= 0;
            end else if (m_active && tvalid && exp_tready()) begin
                m_chan <= (m_cnt == 0) ? chan : m_chan;
                if (m_cnt == WS-1) begin
                    m_fly     <= 1;
                    m_fly_val <= imax(m_max, cur_mag());
                    m_fly_ovr <= m_ovr_acc || cur_full();
                    m_cnt <= 0; m_max <= 0; m_ovr_acc <= 0;
                end else begin
                    m_cnt     <= m_cnt + 1;
                    m_max     <= imax(m_max, cur_mag());
                    m_ovr_acc <= m_ovr_acc || cur_full();
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] w1(input int v);
        return {v[13:0], 18'h0};
    endfunction

    function automatic logic [AW-1:0] w2(input int c1, input int c2);
        return {c1[13:0], 2'b00, c2[13:0], 2'b00};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input logic [AW-1:0] w);
        bit ok;
        ok = 0;
        tdata  = w;
        tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (tready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("send_handshake", ok, 1);
        if (!ok) begin
            $display("FAIL send: ready never returned");
            $fatal(1, "bounded wait expired");
        end
        @(posedge clk); #1;
        tvalid = 1'b0;
    endtask

    task automatic wait_result(input int exp_peak, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid) begin found = 1; break; end
        end
        chk({tag, "_found"}, found, 1);
        if (found) chk(tag, peak, exp_peak);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; en = 1; chan = 0; pready = 1; tvalid = 0; tdata = '0;
        thr_h = 14'd250; thr_l = 14'd100;

        fork
            forever begin
                @(negedge clk);
                chk("tready", tready, int'(exp_tready()));
                chk("valid",  valid,  m_valid);
                chk("peak",   peak,   m_peak);
                chk("above",  above,  m_above);
                chk("below",  below,  m_below);
                chk("ovr",    ovr,    m_ovr_o);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_valid", valid, 0);
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_tready", tready, 1);

        // ch1 window: 10, -300, 200, 5
        send(w1(10)); send(w1(-300)); send(w1(200)); send(w1(5));
        chk("t1_early", valid, 0);
        @(posedge clk); #1;
        chk("t1_valid", valid, 1);
        chk("t1_peak", peak, 300);
        chk("t1_above", above, 1);
        chk("t1_below", below, 0);
        @(posedge clk); #1;
        chk("t1_pulse", valid, 0);

        // ch2 carries -8192, ch1 field carries -8000
        chan = 1;
        send(w2(-8000, -8192)); send(w2(-8000, 100)); send(w2(-8000, -5)); send(w2(-8000, 7));
        wait_result(8192, "t2_peak");
`ifdef IAGC_PEAK_OVERRANGE_EN
        chk("t2_ovr", ovr, 1);
`else
        chk("t2_ovr", ovr, 0);
`endif

        // Back-pressure across two windows
        chan = 0; pready = 0;
        send(w1(1)); send(w1(2)); send(w1(3)); send(w1(40));
        wait_result(40, "t3_first");
        send(w1(5)); send(w1(6)); send(w1(7));
        tdata = w1(-50); tvalid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_tready", tready, 0);
            chk("t3_hold_peak", peak, 40);
            chk("t3_hold_valid", valid, 1);
            @(posedge clk); #1;
        end
        pready = 1;
        #1 chk("t3_ready_back", tready, 1);
        @(posedge clk); #1;
        tvalid = 0;
        chk("t3_consumed", valid, 0);
        @(posedge clk); #1;
        chk("t3_second_valid", valid, 1);
        chk("t3_second_peak", peak, 50);

        // Disable after 2 samples; discarded sample while idle
        send(w1(100)); send(w1(-200));
        en = 0; tvalid = 1; tdata = w1(-1000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_result", valid, 0);
            @(posedge clk); #1;
        end
        tvalid = 0; en = 1;
        @(posedge clk); #1;
        send(w1(3)); send(w1(-7)); send(w1(2)); send(w1(6));
        wait_result(7, "t4_peak");

        // Channel change mid-window
        chan = 0;
        send(w2(11, 900)); send(w2(12, 901));
        chan = 1;
        send(w2(13, 902)); send(w2(14, 903));
        wait_result(14, "t5_old_chan");
        chk("t5_below", below, 1);
        send(w2(500, 21)); send(w2(500, 22)); send(w2(500, -23)); send(w2(500, 20));
        wait_result(23, "t5_new_chan");

        // Asynchronous reset mid-window with a held result
        pready = 0; chan = 0;
        send(w1(1)); send(w1(2)); send(w1(3)); send(w1(4));
        wait_result(4, "t6_peak");
        send(w1(9)); send(w1(9));
        chk("t6_pre_valid", valid, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_tready", tready, 0);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_peak", peak, 0);
        chk("t6_rst_above", above, 0);
        chk("t6_rst_below", below, 0);
        chk("t6_rst_ovr", ovr, 0);
        #10 rst_n = 1;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iagc_peak_detector.md
# iagc_peak_detector

AXI-Stream sink for the ADC capture path. It accepts 32-bit sample words from the Zmod scope controller stream and extracts the selected channel's 14-bit two's-complement sample. Per window of `WINDOW_SIZE` accepted samples it reports the peak absolute magnitude, plus above/below-threshold flags, to the IAGC gain-decision logic over a valid/ready result port. It is the consuming end of the ADC stream and owns `tready`, which the capture path drives today as constant 1.

## Interface
- `ZMOD_DATA_SIZE`, 14, sample width per channel.
- `AXIS_DATA_SIZE`, 32, stream word width.
- `WINDOW_SIZE`, 1024, accepted samples per window; legal range is 4 or more.
- `i_sys_clock` in 1: the single clock; all logic is on its rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_enable` in 1: windowing enable.
- `i_channel` in 1: channel select; 0 = ch1 in `tdata[31:18]`, 1 = ch2 in `tdata[15:2]`.
- `i_thr_high` in `ZMOD_DATA_SIZE`: unsigned upper threshold.
- `i_thr_low` in `ZMOD_DATA_SIZE`: unsigned lower threshold.
- `i_axis_tdata` in `AXIS_DATA_SIZE`: ADC stream data.
- `i_axis_tvalid` in 1: stream valid.
- `o_axis_tready` out 1: stream ready.
- `o_peak` out `ZMOD_DATA_SIZE`: window peak magnitude, unsigned.
- `o_above` out 1: `o_peak` > `i_thr_high`.
- `o_below` out 1: `o_peak` < `i_thr_low`.
- `o_overrange` out 1: at least one full-scale code occurred in the window.
- `o_peak_valid` out 1: result valid.
- `i_peak_ready` in 1: result consumed.

## Operation
- A sample is accepted on a cycle where `i_axis_tvalid && o_axis_tready`.
- Magnitude: `|s|` with `s` signed 14-bit. -8192 maps to 8192 and fits unsigned 14-bit with no wrap.
- Pipeline:
  - Stage 1 registers the magnitude and a last-of-window tag.
  - Stage 2 updates the running max. On a tagged sample, stage 2 loads the output register with `max(acc, mag)` and the flags, then clears `acc`.
- `i_channel` is captured on the first accepted sample of each window. Mid-window changes take effect from the next window.
- Thresholds are sampled on the cycle the output register loads.
- FSM:
  - IDLE: entered on `i_enable`=0. Counter, `acc`, overrange and the pipeline are cleared. `o_axis_tready`=1 and samples are discarded. Goes to ACCUM when `i_enable`=1.
  - ACCUM: counts accepted samples 0..`WINDOW_SIZE`-1, wrapping to 0 after the last. Goes to STALL when the counter is at `WINDOW_SIZE`-1 and `o_peak_valid && !i_peak_ready`.
  - STALL: `o_axis_tready`=0. Returns to ACCUM when `i_peak_ready`=1 or `o_peak_valid`=0.
  - Any state goes to IDLE when `i_enable`=0.
- Result handshake:
  - `o_peak_valid` rises when the output register loads and holds until a cycle with `i_peak_ready`=1.
  - Result fields are stable while valid.
  - Load and consume in the same cycle: the new result replaces the old and valid stays 1.
- Disable mid-window discards the partial window and any in-flight stage. An already-valid output result is kept until consumed.

## Timing
- Reset values: `o_axis_tready`=0 during reset and 1 from the first edge after release; `o_peak`=0; `o_above`=0; `o_below`=0; `o_overrange`=0; `o_peak_valid`=0; state IDLE; counter 0.
- Latency: the result is valid 2 cycles after the handshake of the window's last sample.
- `o_axis_tready` = !(state==STALL). STALL is evaluated combinationally from the registered counter, `o_peak_valid` and `i_peak_ready`, so the ready path from `i_peak_ready` to `o_axis_tready` is combinational.
- The `WINDOW_SIZE` ≥ 4 minimum guarantees the output register is free before the next load.
- `tvalid` gaps only delay the window. Windows are counted in accepted samples, not cycles.

## Configuration
- `IAGC_PEAK_OVERRANGE_EN` defined: `o_overrange` is set when any accepted sample equals +8191 or -8192. It is registered with `o_peak`, and the tracking flag clears at window start.
- `IAGC_PEAK_OVERRANGE_EN` undefined: `o_overrange` is tied to 0 and its tracking logic is removed.

## Test plan
- Reset, then `WINDOW_SIZE`=4, ch1 samples 10, -300, 200, 5, ready=1:
  - `o_peak`=300 with `o_peak_valid` pulsing 1 cycle, 2 cycles after the 4th handshake.
  - With `i_thr_high`=250, `o_above`=1 and `o_below`=0.
- ch2 selected; ch1 field carries -8000 and ch2 field carries -8192 (0x2000 in `tdata[15:2]`):
  - `o_peak`=8192.
  - `o_overrange`=1 with the macro, 0 without it.
- `i_peak_ready`=0 held across two windows:
  - `o_axis_tready` drops exactly at the second window's last sample.
  - The first result is unchanged.
  - Raising `i_peak_ready` restores ready that same cycle, and the second result appears 2 cycles after acceptance.
- Toggle `i_enable` low after 2 of 4 samples, then stream 4 more of 7:
  - The result is 7, from the post-enable window only.
  - No result is emitted for the partial window.
- Change `i_channel` mid-window: the window reports the old channel and the next window uses the new one.
- Assert `i_reset_n`=0 mid-window with `o_peak_valid`=1: all outputs go to their reset values immediately (asynchronously).
